// File: rtl/mult_result_acc.sv
// Dot-product accumulator for the mult11s8s product stream, with a valid/ready result port.
// Define MULT_ACC_SAT_EN to saturate sums at the ACC_W range; otherwise sums wrap and out_sat is 0.
module mult_result_acc #(
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned PROD_W    = 19,
    parameter int unsigned ACC_W     = 22,
    parameter int unsigned NUM_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] prod,
    input  logic              clear,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_sat,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(NUM_TERMS);

    logic [LATENCY-1:0] r_tag;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_acc_out;
    logic               r_overrun;

    logic               w_prod_v;
    logic               w_dump;
    logic [ACC_W-1:0]   w_sum;

    assign w_prod_v = r_tag[LATENCY-1];
    assign w_dump   = w_prod_v && (r_cnt == CNT_W'(NUM_TERMS - 1));

`ifdef MULT_ACC_SAT_EN
    logic [ACC_W:0] w_wide;
    logic           w_ovf;
    logic           r_blk_sat;
    logic           r_out_sat;

    // One guard bit: overflow shows as disagreement between the top two bits.
    assign w_wide = (ACC_W+1)'(signed'(r_acc)) + (ACC_W+1)'(signed'(prod));
    assign w_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];

    always_comb begin
        w_sum = w_wide[ACC_W-1:0];
        if (w_ovf) begin
            w_sum             = {ACC_W{~w_wide[ACC_W]}};
            w_sum[ACC_W-1]    = w_wide[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_sat <= 1'b0;
            r_out_sat <= 1'b0;
        end else if (clear) begin
            r_blk_sat <= 1'b0;
            r_out_sat <= 1'b0;
        end else if (w_dump) begin
            r_out_sat <= r_blk_sat | w_ovf;
            r_blk_sat <= 1'b0;
        end else if (w_prod_v && w_ovf) begin
            r_blk_sat <= 1'b1;
        end
    end

    assign out_sat = r_out_sat;
`else
    assign w_sum   = r_acc + ACC_W'(signed'(prod));
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_acc_out   <= '0;
            r_overrun   <= 1'b0;
        end else if (clear) begin
            r_tag       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_tag <= (r_tag << 1) | LATENCY'(in_valid);
            if (w_dump) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_acc_out   <= w_sum;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready)
                    r_overrun <= 1'b1;
            end else begin
                if (w_prod_v) begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_out_valid && out_ready)
                    r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_mult_result_acc.sv
// Randomized and directed bench for mult_result_acc against an integer-arithmetic reference model.
module tb_mult_result_acc;

    localparam int LATENCY   = 8;
    localparam int PROD_W    = 19;
    localparam int ACC_W     = 22;
    localparam int NUM_TERMS = 16;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [PROD_W-1:0] prod      = '0;
    logic              clear     = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [ACC_W-1:0]  acc_out;
    logic              out_sat;
    logic              overrun;

    always #5 clk = ~clk;

    mult_result_acc #(
        .LATENCY  (LATENCY),
        .PROD_W   (PROD_W),
        .ACC_W    (ACC_W),
        .NUM_TERMS(NUM_TERMS)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .prod     (prod),
        .clear    (clear),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .acc_out  (acc_out),
        .out_sat  (out_sat),
        .overrun  (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: issue cycles of pending terms, running integer sum, expected outputs.
    int     cyc = 0;
    int     q[$];
    longint m_sum = 0;
    int     m_n   = 0;
    bit     m_sat = 1'b0;
    bit     e_valid = 1'b0;
    bit     e_sat   = 1'b0;
    bit     e_ovr   = 1'b0;
    longint e_acc   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint wrap(input longint x);
        logic [ACC_W-1:0] t;
        t = x[ACC_W-1:0];
        return longint'($signed(t));
    endfunction

    function automatic int rand_prod();
        int r;
        r = int'($urandom_range(0, (1 << PROD_W) - 1));
        return (r >= (1 << (PROD_W - 1))) ? r - (1 << PROD_W) : r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_sum = 0; m_n = 0; m_sat = 1'b0;
        e_valid = 1'b0; e_sat = 1'b0; e_ovr = 1'b0; e_acc = 0;
    endtask

    task automatic model_edge(input bit v, input int p, input bit clr, input bit rdy);
        bit dump;
        dump = 1'b0;
        if (clr) begin
            q.delete();
            m_sum = 0; m_n = 0; m_sat = 1'b0;
            e_valid = 1'b0; e_sat = 1'b0; e_ovr = 1'b0;
        end else begin
            if (q.size() > 0 && q[0] == cyc - LATENCY) begin
                void'(q.pop_front());
                m_sum += p;
                m_n++;
`ifdef MULT_ACC_SAT_EN
                if (m_sum > ACC_MAX) begin m_sum = ACC_MAX; m_sat = 1'b1; end
                else if (m_sum < ACC_MIN) begin m_sum = ACC_MIN; m_sat = 1'b1; end
`endif
                dump = (m_n == NUM_TERMS);
            end
            if (dump) begin
                if (e_valid && !rdy) e_ovr = 1'b1;
                e_valid = 1'b1;
                e_acc   = wrap(m_sum);
                e_sat   = m_sat;
                m_sum = 0; m_n = 0; m_sat = 1'b0;
            end else if (e_valid && rdy) begin
                e_valid = 1'b0;
            end
            if (v) q.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, e_valid);
        chk("acc_out", longint'($signed(acc_out)), e_acc);
        chk("out_sat", out_sat, e_sat);
        chk("overrun", overrun, e_ovr);
    endtask

    task automatic step(input bit v, input int p, input bit clr, input bit rdy);
        in_valid  = v;
        prod      = PROD_W'(p);
        clear     = clr;
        out_ready = rdy;
        @(posedge clk);
        model_edge(v, p, clr, rdy);
        #1;
        check_outputs();
    endtask

    task automatic drain(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 12345, 1'b0, rdy);
    endtask

    initial begin
        int k;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // T1: back-to-back +100, latency and sum
        for (int t = 0; t < NUM_TERMS; t++) step(1'b1, 100, 1'b0, 1'b1);
        for (k = 1; k <= 20; k++) begin
            step(1'b0, 100, 1'b0, 1'b1);
            if (out_valid) break;
        end
        chk("t1_latency", k + 1, LATENCY + 1);
        chk("t1_acc", longint'($signed(acc_out)), 1600);
        drain(3, 1'b1);

        // T2: alternating large terms, junk prod on untagged cycles
        for (int t = 0; t < 26; t++)
            step(t < 16, (t >= 8 && t < 24) ? ((t % 2 == 0) ? 131072 : -131071) : 12345, 1'b0, 1'b0);
        chk("t2_acc", longint'($signed(acc_out)), 8);
        drain(2, 1'b1);

        // T3: two blocks without ready -> overrun
        for (int t = 0; t < 45; t++) step(t < 32, (t < 24) ? 1 : 2, 1'b0, 1'b0);
        chk("t3_acc", longint'($signed(acc_out)), 32);
        chk("t3_overrun", overrun, 1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t3_drop", out_valid, 0);
        step(1'b0, 0, 1'b1, 1'b1);

        // T4: range boundary
        for (int t = 0; t < 26; t++) step(t < 16, 262143, 1'b0, 1'b0);
`ifdef MULT_ACC_SAT_EN
        chk("t4_acc", longint'($signed(acc_out)), 2097151);
        chk("t4_sat", out_sat, 1);
`else
        chk("t4_acc", longint'($signed(acc_out)), -16);
        chk("t4_sat", out_sat, 0);
`endif
        drain(2, 1'b1);

        // T5: clear discards in-flight terms
        for (int t = 0; t < 5; t++) step(1'b1, 7, 1'b0, 1'b1);
        step(1'b0, 7, 1'b1, 1'b1);
        for (int t = 0; t < 28; t++) step(t < 16, 1, 1'b0, 1'b0);
        chk("t5_acc", longint'($signed(acc_out)), 16);
        drain(2, 1'b1);

        // T6: async reset mid-block with a pending result
        for (int t = 0; t < 37; t++) step(t < 25, 5, 1'b0, 1'b0);
        chk("t6_pending", out_valid, 1);
        in_valid = 1'b0; prod = '0; clear = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 28; t++) step(t < 16, -3, 1'b0, 1'b0);
        chk("t6_acc", longint'($signed(acc_out)), -48);
        drain(2, 1'b1);

        // Randomized traffic with varying density, ready and occasional clear
        for (int seg = 0; seg < 8; seg++) begin
            int dens;
            dens = int'($urandom_range(1, 4));
            for (int t = 0; t < 500; t++)
                step($urandom_range(0, 4) < dens, rand_prod(),
                     $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
